// File: rtl/approx_mult_pkg.sv
// Shared types and width helpers for the approximate-multiply engine.
package approx_mult_pkg;

    localparam int N_DEFAULT = 16;
    localparam int K_DEFAULT = 8;

    typedef enum logic [3:0] {
        IDLE, FETCH_A, FETCH_B, CAPT_B, NORM, MUL, DENORM, WRITE, DONE
    } state_t;

    // Shift-count width: clog2(N), at least 1 bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Signed de-normalisation shift width: clog2(2N)+1.
    function automatic int dlt_w(input int n);
        return $clog2(2 * n) + 1;
    endfunction

endpackage

// File: rtl/op_normalizer.sv
// Operand register that shifts left until its MSB is set, counting the shifts.
module op_normalizer #(
    parameter int N   = 16,
    parameter int S_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   din,
    output logic [N-1:0]   q,
    output logic [S_W-1:0] cnt,
    output logic           zero,
    output logic           fin
);

    assign zero = (q == '0);
    // A zero operand never reaches MSB=1, so it counts as finished.
    assign fin  = zero | q[N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            q   <= din;
            cnt <= '0;
        end else if (step && !fin) begin
            q   <= {q[N-2:0], 1'b0};
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/approx_mult_engine.sv
// Block engine: reads A/B pairs, forms truncated-operand products, writes 2N-bit results.
module approx_mult_engine
    import approx_mult_pkg::*;
#(
    parameter int N      = 16,
    parameter int K      = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              exact_mode,
    input  logic [ADDR_W-1:0] n_pairs,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [N-1:0]      rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2*N-1:0]    wr_data,
    output logic              busy,
    output logic              done
);

    localparam int S_W = cnt_w(N);
    localparam int D_W = dlt_w(N);
    localparam logic signed [D_W-1:0] D_MAX = D_W'(2 * (N - K));

    state_t                  state, ns;
    logic [ADDR_W-1:0]       i, ni, n_lat;
    logic                    ex_lat;
    logic [2*N-1:0]          result;
    logic signed [D_W-1:0]   d, d_calc;

    logic [N-1:0]   qa, qb;
    logic [S_W-1:0] sa, sb;
    logic           za, zb, fa, fb;
    logic [2*K-1:0] prod_top;
    logic [2*N-1:0] prod_full;

    op_normalizer #(.N(N), .S_W(S_W)) u_norm_a (
        .clk(clk), .rst(rst), .load(state == FETCH_B), .step(state == NORM),
        .din(rd_data), .q(qa), .cnt(sa), .zero(za), .fin(fa)
    );

    op_normalizer #(.N(N), .S_W(S_W)) u_norm_b (
        .clk(clk), .rst(rst), .load(state == CAPT_B), .step(state == NORM),
        .din(rd_data), .q(qb), .cnt(sb), .zero(zb), .fin(fb)
    );

    assign prod_top  = qa[N-1 -: K] * qb[N-1 -: K];
    assign prod_full = qa * qb;
    assign d_calc    = D_MAX - $signed({{(D_W-S_W){1'b0}}, sa})
                             - $signed({{(D_W-S_W){1'b0}}, sb});
    assign wr_data   = result;

    always_comb begin
        ns = state;
        ni = i;
        case (state)
            IDLE:    if (start) begin
                         ni = '0;
                         ns = (n_pairs == '0) ? DONE : FETCH_A;
                     end
            FETCH_A: ns = FETCH_B;
            FETCH_B: ns = CAPT_B;
            CAPT_B:  ns = ex_lat ? MUL : NORM;
            NORM:    if (fa && fb) ns = MUL;
            MUL:     ns = ex_lat ? WRITE : DENORM;
            DENORM:  if (d == '0) ns = WRITE;
            WRITE:   if (i == n_lat - 1'b1) ns = DONE;
                     else begin
                         ni = i + 1'b1;
                         ns = FETCH_A;
                     end
            DONE:    ns = IDLE;
            default: ns = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            i       <= '0;
            n_lat   <= '0;
            ex_lat  <= 1'b0;
            result  <= '0;
            d       <= '0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                n_lat  <= n_pairs;
                ex_lat <= exact_mode;
            end
            if (state == MUL) begin
                if (ex_lat) begin
                    result <= prod_full;
                end else if (za || zb) begin
                    result <= '0;
                    d      <= '0;
                end else begin
                    result <= (2*N)'(prod_top);
                    d      <= d_calc;
                end
            end
            if (state == DENORM) begin
                if (d > 0) begin
                    result <= result << 1;
                    d      <= d - 1'b1;
                end else if (d < 0) begin
                    result <= result >> 1;
                    d      <= d + 1'b1;
                end
            end
            state   <= ns;
            i       <= ni;
            busy    <= (ns != IDLE);
            done    <= (ns == DONE);
            wr_en   <= (ns == WRITE);
            wr_addr <= (ns == WRITE) ? ni : '0;
            rd_addr <= (ns == FETCH_A) ? {ni[ADDR_W-2:0], 1'b0} :
                       (ns == FETCH_B) ? {ni[ADDR_W-2:0], 1'b1} : '0;
        end
    end

endmodule

// File: tb/tb_approx_mult_engine.sv
// Scoreboard bench for approx_mult_engine with directed, hand-computed vectors.
module tb_approx_mult_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        exact_mode = 1'b0;
    logic [7:0]  n_pairs = '0;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data = '0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;

    approx_mult_engine #(.N(16), .K(8), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .exact_mode(exact_mode),
        .n_pairs(n_pairs), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    always @(posedge clk) rd_data <= mem[rd_addr];

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endfunction

    // Monitor: pops an expectation for every write strobe.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en === 1'b1) begin
            wr_cnt++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr %0h data %0h", wr_addr, wr_data);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", {56'd0, wr_addr}, {56'd0, e.a});
                chk("wr_data", {32'd0, wr_data}, {32'd0, e.d});
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic set_pair(input int idx, input logic [15:0] a, input logic [15:0] b);
        mem[2*idx]   = a;
        mem[2*idx+1] = b;
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        sbq.push_back(e);
    endtask

    task automatic kick(input logic [7:0] n, input logic ex);
        @(negedge clk);
        n_pairs    = n;
        exact_mode = ex;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycles counted from the edge that sampled start to the one raising done.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            if (done === 1'b1) break;
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 3000) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got none expected done pulse");
        end
    endtask

    task automatic one(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic ex, input logic [31:0] res, input int lat);
        int c;
        set_pair(0, a, b);
        push(8'h00, res);
        kick(8'd1, ex);
        wait_done(c);
        chk({nm, "_latency"}, 64'(c), 64'(lat));
    endtask

    initial begin
        int c;
        int t;
        for (int k = 0; k < 256; k++) mem[k] = '0;

        repeat (3) @(negedge clk);
        chk("rst_rd_addr", {56'd0, rd_addr}, 64'd0);
        chk("rst_wr_en",   {63'd0, wr_en},   64'd0);
        chk("rst_wr_addr", {56'd0, wr_addr}, 64'd0);
        chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
        chk("rst_busy",    {63'd0, busy},    64'd0);
        chk("rst_done",    {63'd0, done},    64'd0);
        rst = 1'b0;

        // Latency = 3 + (max(s1,s2)+1) + 1 + (|d|+1) + 1, or 5 in exact mode.
        one("msb_set",   16'h8000, 16'h8000, 1'b0, 32'h4000_0000, 23);
        one("mixed",     16'h1234, 16'h00FF, 1'b0, 32'h0012_0DE0, 20);
        one("exact",     16'h1234, 16'h00FF, 1'b1, 32'h0012_21CC, 5);
        one("lsb_only",  16'h0001, 16'h0001, 1'b0, 32'h0000_0001, 36);
        one("zero_op",   16'h0000, 16'hFFFF, 1'b0, 32'h0000_0000, 7);
        one("exact_max", 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001, 5);

        // Three-pair block, with a stray start mid-block that must be ignored.
        set_pair(0, 16'h8000, 16'h8000);
        set_pair(1, 16'h1234, 16'h00FF);
        set_pair(2, 16'h0000, 16'hFFFF);
        push(8'h00, 32'h4000_0000);
        push(8'h01, 32'h0012_0DE0);
        push(8'h02, 32'h0000_0000);
        @(negedge clk);
        wr_cnt = 0;
        done_cnt = 0;
        kick(8'd3, 1'b0);
        repeat (3) @(negedge clk);
        start   = 1'b1;
        n_pairs = 8'd0;
        @(negedge clk);
        start   = 1'b0;
        wait_done(c);
        @(negedge clk);
        chk("blk3_writes", 64'(wr_cnt), 64'd3);
        chk("blk3_dones",  64'(done_cnt), 64'd1);
        chk("blk3_idle",   {63'd0, busy}, 64'd0);

        // Empty block: done right away, no writes.
        wr_cnt = 0;
        done_cnt = 0;
        kick(8'd0, 1'b0);
        wait_done(c);
        chk("empty_latency", 64'(c), 64'd0);
        @(negedge clk);
        chk("empty_writes", 64'(wr_cnt), 64'd0);
        chk("empty_dones",  64'(done_cnt), 64'd1);

        // Reset while pair 1 is normalising.
        set_pair(0, 16'h8000, 16'h8000);
        set_pair(1, 16'h0001, 16'h0001);
        push(8'h00, 32'h4000_0000);
        wr_cnt = 0;
        done_cnt = 0;
        kick(8'd2, 1'b0);
        t = 0;
        while (wr_cnt < 1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            total++;
            bad++;
            $display("FAIL first_write_timeout: got %0d writes expected 1", wr_cnt);
        end
        repeat (6) @(negedge clk);
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",    {63'd0, busy},    64'd0);
        chk("abort_rd_addr", {56'd0, rd_addr}, 64'd0);
        chk("abort_wr_data", {32'd0, wr_data}, 64'd0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("abort_writes", 64'(wr_cnt), 64'd1);
        chk("abort_dones",  64'(done_cnt), 64'd0);

        one("after_abort", 16'h8000, 16'h8000, 1'b0, 32'h4000_0000, 23);
        @(negedge clk);
        chk("after_abort_dones", 64'(done_cnt), 64'd1);
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
